slot_allocator: RTL
===================

Name: slot_allocator

Overview:
- Tracks a pool of NUM_SLOT tags (ROB entries, physical registers, MSHRs) as a registered busy bitmap.
- Hands out the lowest-index free slot through a valid/ready allocate port.
- Accepts slot releases on a free port, and supports a whole-pool flush.
- Lowest-free selection drives the existing priority_encoder (NUM_WIRE=NUM_SLOT) with the inverted busy vector. This block is the stage directly upstream of it and also consumes its index.

Parameters:
NUM_SLOT, 16, number of allocatable slots; must be ≥2 and a power of two.

Ports:
clk_i  input  1  clock, all state updates on rising edge
arst_ni  input  1  asynchronous active-low reset
alloc_valid_i  input  1  requester wants a slot this cycle
alloc_ready_o  output  1  at least one slot free
alloc_idx_o  output  $clog2(NUM_SLOT)  index granted when alloc_valid_i & alloc_ready_o
free_valid_i  input  1  release a slot this cycle
free_idx_i  input  $clog2(NUM_SLOT)  slot to release
flush_i  input  1  release all slots
busy_o  output  NUM_SLOT  current busy bitmap (bit i = slot i allocated)
count_o  output  $clog2(NUM_SLOT+1)  number of busy slots
full_o  output  1  count_o == NUM_SLOT
empty_o  output  1  count_o == 0

Behaviour:
- Reset (arst_ni low, async): busy=0, count=0.
  - Hence alloc_ready_o=1, alloc_idx_o=0, full_o=0, empty_o=1, busy_o=0.
  - Reset mid-operation discards all allocations immediately.
- All outputs are combinational from registered state only; there is no input-to-output combinational path.
- Selection and readiness:
  - alloc_idx_o = lowest i with busy[i]=0; slot 0 is highest priority.
  - When full, alloc_idx_o is don't-care (drive 0).
  - alloc_ready_o = ~full_o.
- Allocate fire = alloc_valid_i & alloc_ready_o.
  - Next cycle busy[alloc_idx_o]=1.
  - Single-cycle latency; one allocation per cycle max.
- Free: free_valid_i with busy[free_idx_i]=1 → next cycle busy[free_idx_i]=0.
- No bypass: a slot freed in cycle N is allocatable from cycle N+1 onward, never in cycle N.
  - When full, alloc_ready_o stays 0 in the free cycle even if a free is presented.
- Simultaneous alloc and free (different slots): both apply; count unchanged.
- Free of an already-free slot is a no-op. This includes the slot being allocated in the same cycle; alloc wins and the slot ends busy.
- flush_i has the highest priority over alloc and free.
  - Next cycle busy=0, count=0.
  - An alloc fire in a flush cycle is lost. The requester must treat the grant as cancelled.
- count register:
  - +1 on alloc fire, −1 on effective free, net 0 when both occur.
  - Never wraps; invariant count_o == popcount(busy_o) is required at all times.
- full_o and empty_o are decoded from count.

Optional Feature:
- Macro SLOT_ALLOC_ERR_EN.
- When defined:
  - Adds output err_o (1 bit), a sticky register with reset value 0.
  - err_o is set on any free_valid_i whose target slot is not busy (double free), excluding flush cycles.
  - err_o is also set on alloc_valid_i while full is held for more than NUM_SLOT consecutive cycles (starvation watchdog, NUM_SLOT-width counter).
  - err_o is cleared only by reset or flush_i.
- When undefined: no err_o port and no watchdog counter; illegal frees are silently ignored as above.

Test Plan:
- Reset then 4 back-to-back alloc fires, NUM_SLOT=4 → alloc_idx_o 0,1,2,3 on successive cycles; then busy_o=4'b1111, full_o=1, alloc_ready_o=0, count_o=4.
- Full pool; free slot 2 in cycle N with alloc_valid_i=1 → no grant in cycle N; cycle N+1 alloc_ready_o=1, alloc_idx_o=2; granted; busy_o=4'b1111 again.
- busy=4'b0011; alloc fire (idx 2) and free slot 0 in the same cycle → next busy_o=4'b0110, count_o=2, alloc_idx_o=0.
- busy=4'b0101; flush_i=1 with alloc_valid_i=1 and free_valid_i=1 (idx 0) → next busy_o=0, count_o=0, empty_o=1, alloc_idx_o=0.
- SLOT_ALLOC_ERR_EN defined, busy=4'b0001; free slot 3 → busy unchanged, err_o=1 next cycle and held; flush_i → err_o=0.
- Random alloc/free/flush for 10k cycles with a scoreboard model → count_o==popcount(busy_o) every cycle, no duplicate grants, alloc_idx_o always lowest free slot; assert arst_ni mid-run → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/slot_allocator.sv
// Purpose : tracks a pool of NUM_SLOT tags as a registered busy bitmap; grants the lowest free slot.
// Latency : grant index is visible in the request cycle; busy/count reflect alloc/free/flush one cycle later.
// Backpres: alloc_ready_o drops while the pool is full; a free only reopens the pool the following cycle.
//
// Ports:
//   clk_i, arst_ni            clock, async active-low reset
//   alloc_valid_i/ready_o     allocate handshake, alloc_idx_o = granted slot
//   free_valid_i, free_idx_i  release one slot
//   flush_i                   release all slots (beats alloc and free)
//   busy_o, count_o           busy bitmap and its population count
//   full_o, empty_o           decoded from count
//   err_o                     sticky double-free / starvation flag (only with SLOT_ALLOC_ERR_EN)
//
// Optional feature macro: SLOT_ALLOC_ERR_EN
module slot_allocator #(
  parameter int NUM_SLOT = 16,
  localparam int IDX_W = $clog2(NUM_SLOT),
  localparam int CNT_W = $clog2(NUM_SLOT + 1)
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic                alloc_valid_i,
  output logic                alloc_ready_o,
  output logic [IDX_W-1:0]    alloc_idx_o,
  input  logic                free_valid_i,
  input  logic [IDX_W-1:0]    free_idx_i,
  input  logic                flush_i,
  output logic [NUM_SLOT-1:0] busy_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                full_o,
  output logic                empty_o
`ifdef SLOT_ALLOC_ERR_EN
  ,
  output logic                err_o
`endif
);

  logic [NUM_SLOT-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [IDX_W-1:0]    free_slot;
  logic                full;
  logic                alloc_fire;
  logic                free_eff;

  // Lowest-index free slot. Scanning from the top down lets the lowest
  // match overwrite the others; a full pool leaves the default of 0.
  always_comb begin
    free_slot = '0;
    for (int i = NUM_SLOT - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_slot = IDX_W'(i);
    end
  end

  assign full       = (count_q == CNT_W'(NUM_SLOT));
  assign alloc_fire = alloc_valid_i & ~full;
  // A free only counts when the slot is currently busy. The slot being
  // granted this cycle is never busy, so alloc wins that collision.
  assign free_eff   = free_valid_i & busy_q[free_idx_i];

  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    if (flush_i) begin
      busy_d  = '0;
      count_d = '0;
    end else begin
      if (free_eff)   busy_d[free_idx_i] = 1'b0;
      if (alloc_fire) busy_d[free_slot]  = 1'b1;
      if (alloc_fire && !free_eff)      count_d = count_q + CNT_W'(1);
      else if (!alloc_fire && free_eff) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Outputs depend only on registered state; readiness ignores the
  // same-cycle free so a freed slot is never re-granted in its free cycle.
  assign alloc_ready_o = ~full;
  assign alloc_idx_o   = free_slot;
  assign busy_o        = busy_q;
  assign count_o       = count_q;
  assign full_o        = full;
  assign empty_o       = (count_q == '0);

`ifdef SLOT_ALLOC_ERR_EN
  // full_cnt_q counts consecutive full cycles, saturating at NUM_SLOT.
  // A request seen once NUM_SLOT full cycles have already elapsed means
  // the pool has been stuck for more than NUM_SLOT cycles.
  logic [NUM_SLOT-1:0] full_cnt_q;
  logic                err_q;
  logic                dbl_free;
  logic                starve;

  assign dbl_free = free_valid_i & ~busy_q[free_idx_i] & ~flush_i;
  assign starve   = alloc_valid_i & full & (full_cnt_q >= NUM_SLOT'(NUM_SLOT));

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      full_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (flush_i || !full)                         full_cnt_q <= '0;
      else if (full_cnt_q < NUM_SLOT'(NUM_SLOT))    full_cnt_q <= full_cnt_q + NUM_SLOT'(1);

      if (flush_i)                 err_q <= 1'b0;
      else if (dbl_free || starve) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`endif

endmodule
